uart_host_master: RTL and testbench

UART_HOST_MASTER -- requirements
Module: uart_host_master

---
 rtl/uart_host_master.sv | 148 ++++++++++++++
 tb/tb_uart_host_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_master.sv
// uart_host_master
// Drives a three-byte request (op_a, op_b, opcode) through an external UART
// transmitter, then waits a bounded time for a single response byte from the
// UART receiver. o_done pulses at the end of every transaction; o_timeout
// marks the pulses where no response byte arrived in time.

module uart_host_master #(
  parameter int NB_BITS        = 8,
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_BITS-1:0] i_op_a,
  input  logic [NB_BITS-1:0] i_op_b,
  input  logic [NB_BITS-1:0] i_opcode,
  output logic [NB_BITS-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  input  logic [NB_BITS-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_BITS-1:0] o_result,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    WAIT_RX,
    DONE
  } state_t;

  // Last count value spent in WAIT_RX; reaching it without a response ends
  // the transaction as a timeout.
  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic [1:0]          byte_idx;
  logic [1:0]          next_idx;
  logic [NB_BITS-1:0]  op_a_q;
  logic [NB_BITS-1:0]  op_b_q;
  logic [NB_BITS-1:0]  opcode_q;
  logic [NB_BITS-1:0]  next_byte;
  logic [NB_TIMEOUT-1:0] tmo_cnt;
  logic                tmo_flag;

  assign next_idx = byte_idx + 2'd1;

  // Select the captured byte that follows the one currently being sent.
  always_comb begin
    next_byte = opcode_q;
    case (next_idx)
      2'd0:    next_byte = op_a_q;
      2'd1:    next_byte = op_b_q;
      default: next_byte = opcode_q;
    endcase
  end

  // Transaction sequencer with all outputs registered alongside the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      byte_idx   <= 2'd0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      opcode_q   <= '0;
      tmo_cnt    <= '0;
      tmo_flag   <= 1'b0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_result   <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            op_a_q     <= i_op_a;
            op_b_q     <= i_op_b;
            opcode_q   <= i_opcode;
            byte_idx   <= 2'd0;
            o_tx_data  <= i_op_a;
            o_tx_start <= 1'b1;
            o_busy     <= 1'b1;
            state      <= SEND;
          end
        end

        SEND: begin
          o_tx_start <= 1'b0;
          state      <= WAIT_TX;
        end

        WAIT_TX: begin
          if (i_tx_done) begin
            if (byte_idx == 2'd2) begin
              tmo_cnt <= '0;
              state   <= WAIT_RX;
            end else begin
              byte_idx   <= next_idx;
              o_tx_data  <= next_byte;
              o_tx_start <= 1'b1;
              state      <= SEND;
            end
          end
        end

        WAIT_RX: begin
          if (i_rx_done) begin
            o_result  <= i_rx_data;
            tmo_flag  <= 1'b0;
            o_done    <= 1'b1;
            o_timeout <= 1'b0;
            state     <= DONE;
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            tmo_flag  <= 1'b1;
            o_done    <= 1'b1;
            o_timeout <= 1'b1;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        DONE: begin
          o_done    <= 1'b0;
          o_timeout <= 1'b0;
          o_busy    <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          o_tx_start <= 1'b0;
          o_done     <= 1'b0;
          o_timeout  <= 1'b0;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_master.sv
// tb_uart_host_master
// Plays the roles of UART transmitter and receiver around uart_host_master,
// runs table-driven and random transactions and compares every observable
// output against expectations built from the transaction-level rules.

module tb_uart_host_master;

  localparam int T = 10;
  localparam logic [7:0] ONE  = 8'h01;
  localparam logic [7:0] ZERO = 8'h00;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_op_a;
  logic [7:0] i_op_b;
  logic [7:0] i_opcode;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       i_tx_done;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic [7:0] o_result;
  logic       o_busy;
  logic       o_done;
  logic       o_timeout;

  int checks;
  int errors;

  // Response byte the model believes o_result holds between transactions.
  logic [7:0] model_result;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    int         tx_lat;
    int         rx_lat;
    logic [7:0] rx_byte;
    bit         stray;
    logic [7:0] exp_result;
    bit         exp_timeout;
  } vec_t;

  vec_t vecs[5];

  uart_host_master #(
    .NB_BITS(8),
    .NB_TIMEOUT(16),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_op_a(i_op_a),
    .i_op_b(i_op_b),
    .i_opcode(i_opcode),
    .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start),
    .i_tx_done(i_tx_done),
    .i_rx_data(i_rx_data),
    .i_rx_done(i_rx_done),
    .o_result(o_result),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_timeout(o_timeout)
  );

  // Free-running clock, period 10.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkIdleZero(input string name);
    checkOutput({name, "_tx_data"}, o_tx_data, ZERO);
    checkOutput({name, "_tx_start"}, 8'(o_tx_start), ZERO);
    checkOutput({name, "_result"}, o_result, ZERO);
    checkOutput({name, "_busy"}, 8'(o_busy), ZERO);
    checkOutput({name, "_done"}, 8'(o_done), ZERO);
    checkOutput({name, "_timeout"}, 8'(o_timeout), ZERO);
  endtask

  // Drive a request in the IDLE cycle; captured on the next rising edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    i_op_a   = a;
    i_op_b   = b;
    i_opcode = op;
    i_start  = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Transaction-level reference: a reply inside the window replaces the result,
  // otherwise the old result stays and the transaction is a timeout.
  task automatic modelTxn(input int rx_lat, input logic [7:0] rx_byte,
                          output logic [7:0] r, output bit to);
    if (rx_lat >= 0 && rx_lat < T) begin
      r  = rx_byte;
      to = 1'b0;
    end else begin
      r  = model_result;
      to = 1'b1;
    end
  endtask

  // Starting in the SEND cycle of one byte: check the offer, hold, acknowledge.
  task automatic txPhase(input string name, input logic [7:0] exp_byte, input int lat, input bit stray);
    checkOutput({name, "_start"}, 8'(o_tx_start), ONE);
    checkOutput({name, "_data"}, exp_byte, exp_byte == o_tx_data ? exp_byte : o_tx_data);
    checkOutput({name, "_busy"}, 8'(o_busy), ONE);
    checkOutput({name, "_done"}, 8'(o_done), ZERO);
    i_op_a   = 8'($urandom);
    i_op_b   = 8'($urandom);
    i_opcode = 8'($urandom);
    @(negedge i_clk);
    for (int c = 1; c <= lat; c++) begin
      checkOutput({name, "_hold_start"}, 8'(o_tx_start), ZERO);
      checkOutput({name, "_hold_data"}, o_tx_data, exp_byte);
      if (stray && c == ((lat < 2) ? lat : 2)) begin
        i_start   = 1'b1;
        i_rx_done = 1'b1;
        i_rx_data = 8'($urandom);
      end
      if (c == lat) i_tx_done = 1'b1;
      @(negedge i_clk);
      i_tx_done = 1'b0;
      i_start   = 1'b0;
      i_rx_done = 1'b0;
    end
  endtask

  // One complete request/response transaction, starting at a negedge in IDLE.
  task automatic runTxn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        input int tx_lat, input int rx_lat, input logic [7:0] rx_byte,
                        input bit stray, input logic [7:0] exp_result, input bit exp_timeout);
    int last;
    checkOutput("idle_busy", 8'(o_busy), ZERO);
    applyStimulus(a, b, op);
    txPhase("byte0", a, tx_lat, 1'b0);
    txPhase("byte1", b, tx_lat, stray);
    txPhase("byte2", op, tx_lat, 1'b0);
    last = (rx_lat >= 0 && rx_lat < T) ? rx_lat : T - 1;
    for (int k = 0; k <= last; k++) begin
      checkOutput("rx_wait_done", 8'(o_done), ZERO);
      checkOutput("rx_wait_timeout", 8'(o_timeout), ZERO);
      checkOutput("rx_wait_busy", 8'(o_busy), ONE);
      i_rx_data = 8'($urandom);
      if (stray && k == 0) i_tx_done = 1'b1;
      if (k == rx_lat) begin
        i_rx_done = 1'b1;
        i_rx_data = rx_byte;
      end
      @(negedge i_clk);
      i_rx_done = 1'b0;
      i_tx_done = 1'b0;
    end
    checkOutput("done_pulse", 8'(o_done), ONE);
    checkOutput("done_timeout", 8'(o_timeout), 8'(exp_timeout));
    checkOutput("done_result", o_result, exp_result);
    checkOutput("done_tx_start", 8'(o_tx_start), ZERO);
    @(negedge i_clk);
    checkOutput("after_done", 8'(o_done), ZERO);
    checkOutput("after_timeout", 8'(o_timeout), ZERO);
    checkOutput("after_busy", 8'(o_busy), ZERO);
    checkOutput("after_result", o_result, exp_result);
    model_result = exp_result;
  endtask

  // Main sequence: reset, vector table, random traffic, mid-transaction reset.
  initial begin
    logic [7:0] r;
    bit         to;
    logic [7:0] ra, rb, rop, rbyte;
    int         rtx, rrx;
    bit         rstray;

    checks = 0;
    errors = 0;
    model_result = 8'h00;

    vecs[0] = '{8'h05, 8'h03, 8'h20, 20, 4,  8'h08, 1'b0, 8'h08, 1'b0};
    vecs[1] = '{8'h11, 8'h22, 8'h33, 2,  -1, 8'h00, 1'b0, 8'h08, 1'b1};
    vecs[2] = '{8'h44, 8'h55, 8'h66, 1,  9,  8'hAA, 1'b0, 8'hAA, 1'b0};
    vecs[3] = '{8'h77, 8'h88, 8'h99, 5,  0,  8'h3C, 1'b1, 8'h3C, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 8'h80, 1,  -1, 8'h00, 1'b1, 8'h3C, 1'b1};

    i_rst     = 1'b1;
    i_start   = 1'b0;
    i_op_a    = 8'h00;
    i_op_b    = 8'h00;
    i_opcode  = 8'h00;
    i_tx_done = 1'b0;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    repeat (2) @(negedge i_clk);
    checkIdleZero("reset");
    i_rst = 1'b0;
    @(negedge i_clk);

    for (int v = 0; v < 5; v++) begin
      runTxn(vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].tx_lat, vecs[v].rx_lat,
             vecs[v].rx_byte, vecs[v].stray, vecs[v].exp_result, vecs[v].exp_timeout);
    end

    for (int n = 0; n < 8; n++) begin
      ra     = 8'($urandom);
      rb     = 8'($urandom);
      rop    = 8'($urandom);
      rbyte  = 8'($urandom);
      rtx    = int'($urandom_range(1, 4));
      rrx    = int'($urandom_range(0, 13));
      rstray = 1'($urandom_range(0, 1));
      modelTxn(rrx, rbyte, r, to);
      runTxn(ra, rb, rop, rtx, rrx, rbyte, rstray, r, to);
    end

    applyStimulus(8'hDE, 8'hAD, 8'hBE);
    txPhase("abort_byte0", 8'hDE, 2, 1'b0);
    txPhase("abort_byte1", 8'hAD, 2, 1'b0);
    checkOutput("abort_byte2_start", 8'(o_tx_start), ONE);
    checkOutput("abort_byte2_data", o_tx_data, 8'hBE);
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    checkIdleZero("async_reset");
    @(negedge i_clk);
    i_rst = 1'b0;
    model_result = 8'h00;
    i_tx_done = 1'b1;
    @(negedge i_clk);
    i_tx_done = 1'b0;
    checkOutput("post_reset_tx_start", 8'(o_tx_start), ZERO);
    checkOutput("post_reset_busy", 8'(o_busy), ZERO);
    i_rx_done = 1'b1;
    i_rx_data = 8'h55;
    @(negedge i_clk);
    i_rx_done = 1'b0;
    checkOutput("post_reset_result", o_result, ZERO);
    checkOutput("post_reset_done", 8'(o_done), ZERO);
    runTxn(8'h12, 8'h34, 8'h56, 3, -1, 8'h00, 1'b0, 8'h00, 1'b1);
    runTxn(8'h9A, 8'hBC, 8'hDE, 2, 3, 8'h6B, 1'b0, 8'h6B, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
